hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and flush controller for the five-stage RISC-V core, which has no forwarding paths. A three-entry destination-register scoreboard tracks writes in flight in the E, M and W stages. From it the block stalls the F/D boundary and inserts bubbles at D/E. It also kills wrong-path instructions after a branch or jump redirect and keeps free-running stall and flush event counters for the simulation bench.

## Interface
Parameters:
- SHADOW, default 1: extra cycles after a redirect during which the decode-stage instruction is wrong-path and must be killed (range 0–3).
- CNT_W, default 32: width of the event counters.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  reset, synchronous, active-high.
- D_VALID  in  1  decode stage holds a real instruction.
- D_RS1  in  5  decode-stage rs1 index.
- D_RS2  in  5  decode-stage rs2 index.
- D_USE_RS1  in  1  instruction reads rs1.
- D_USE_RS2  in  1  instruction reads rs2.
- D_RD  in  5  decode-stage rd index.
- D_REGWRT  in  1  instruction writes rd.
- REDIRECT  in  1  a taken branch or jump was resolved this cycle and fetch is being retargeted.
- STALL  out  1  hold the FD_PC/FD_IR boundary.
- BUBBLE_DE  out  1  load a NOP (0x00000013, control signals zero) into the D/E boundary.
- FLUSH_FD  out  1  load a NOP into FD_IR at the next edge.
- SB_BUSY  out  3  valid bits of the scoreboard entries; bit 0 = E, bit 1 = M, bit 2 = W.
- STALL_CNT  out  CNT_W  number of cycles with STALL=1.
- FLUSH_CNT  out  CNT_W  number of REDIRECT events accepted.

## Operation
- Scoreboard: SB[0..2] = {valid, rd[4:0]} for the E, M and W stages.
  - The register file is not write-through, so an entry in W still blocks a read.
- Match rules:
  - match(r) = r≠0 and some SB[i].valid with SB[i].rd = r.
  - Register x0 never causes a hazard.
  - If rs1 = rs2 and both match, the result is a single STALL, not a double count.
- Kill state: kill = REDIRECT or shadow_cnt ≠ 0.
- STALL = D_VALID and !kill and ((D_USE_RS1 and match(D_RS1)) or (D_USE_RS2 and match(D_RS2))).
- BUBBLE_DE = STALL or kill.
- FLUSH_FD = kill.
- Scoreboard update at each edge (RESET low):
  - SB[2] ← SB[1].
  - SB[1] ← SB[0].
  - SB[0] ← {1, D_RD} if D_VALID and D_REGWRT and D_RD≠0 and !STALL and !kill; otherwise {0, 0}.
- Shadow counter (2 bits):
  - REDIRECT loads SHADOW.
  - Otherwise it decrements when nonzero and saturates at 0.
  - A REDIRECT that arrives while the counter is nonzero reloads it; it does not add to it.
- Counters:
  - STALL_CNT increments on each cycle with STALL=1.
  - FLUSH_CNT increments on each cycle with REDIRECT=1.
  - Both wrap modulo 2^CNT_W.
- Simultaneous events: REDIRECT overrides a hazard. STALL=0 in that cycle, and the decode instruction is bubbled, not held.

## Timing
- STALL, BUBBLE_DE and FLUSH_FD are combinational from the inputs and registered state, with zero-cycle latency.
- Stall length when the producer sits directly ahead of the consumer:
  - producer in E: 3 cycles;
  - producer in M: 2 cycles;
  - producer in W: 1 cycle.
  - The consumer's D_VALID is released in the cycle after the producer's entry leaves W.
- Redirect: FLUSH_FD is high for 1 + SHADOW cycles, starting in the REDIRECT cycle.
- Reset, while RESET is high and at the first edge:
  - SB entries are cleared to invalid with rd 0.
  - shadow_cnt, STALL_CNT and FLUSH_CNT are cleared to 0.
  - STALL, BUBBLE_DE and FLUSH_FD are forced to 0, regardless of inputs.
  - SB_BUSY reads 0.
- Reset mid-stall or mid-shadow: all state is cleared at the edge. The first cycle after reset has no hazard unless new entries are written.

## Test plan
- Producer x5 (D_RD=5, D_REGWRT=1) followed immediately by a consumer reading rs1=5 -> STALL=1 for exactly 3 cycles, SB_BUSY sequence 001, 010, 100, then 000; STALL_CNT=3.
- Producer writes x0, followed by a consumer of x0 -> STALL never asserts and SB_BUSY stays 000.
- Consumer with rs1=rs2=7 while x7 is in M -> 2 stall cycles; STALL_CNT advances by 2 only.
- REDIRECT pulse with SHADOW=1 while a decode hazard is pending -> STALL=0; BUBBLE_DE=FLUSH_FD=1 for 2 cycles; no SB entry is written; FLUSH_CNT=1.
- Second REDIRECT while shadow_cnt=1 -> the counter reloads and FLUSH_FD stays high for 2 more cycles; FLUSH_CNT=2.
- RESET asserted during the second stall cycle -> all outputs are 0 in the next cycle, SB_BUSY=000 and both counters are 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and flush controller for the five-stage, no-forwarding RISC-V pipeline.
//
// A three-entry scoreboard records the destination registers of instructions that are
// in flight in the E, M and W stages. Any decode-stage source that matches a live
// entry stalls the F/D boundary and bubbles D/E until the producer has left W. The
// register file is not write-through, so an entry in W still blocks a read.
// A redirect, plus SHADOW cycles after it, kills the decode-stage instruction.
//
// Ports:
//   CLK        in   rising-edge clock
//   RESET      in   synchronous, active-high reset
//   D_VALID    in   decode stage holds a real instruction
//   D_RS1/RS2  in   decode source register indices
//   D_USE_RS1  in   instruction reads rs1
//   D_USE_RS2  in   instruction reads rs2
//   D_RD       in   decode destination register index
//   D_REGWRT   in   instruction writes rd
//   REDIRECT   in   taken branch/jump resolved this cycle
//   STALL      out  hold FD_PC/FD_IR
//   BUBBLE_DE  out  load a NOP into the D/E boundary
//   FLUSH_FD   out  load a NOP into FD_IR at the next edge
//   SB_BUSY    out  scoreboard valid bits {W, M, E}
//   STALL_CNT  out  cycles with STALL=1 (wraps)
//   FLUSH_CNT  out  cycles with REDIRECT=1 (wraps)

module hazard_ctrl #(
  parameter int unsigned SHADOW = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             D_VALID,
  input  logic [4:0]       D_RS1,
  input  logic [4:0]       D_RS2,
  input  logic             D_USE_RS1,
  input  logic             D_USE_RS2,
  input  logic [4:0]       D_RD,
  input  logic             D_REGWRT,
  input  logic             REDIRECT,
  output logic             STALL,
  output logic             BUBBLE_DE,
  output logic             FLUSH_FD,
  output logic [2:0]       SB_BUSY,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  // Index 0 = E, 1 = M, 2 = W.
  sb_entry_t [2:0]  sb_q, sb_d;
  logic [1:0]       shadow_cnt_q, shadow_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic rs1_match;
  logic rs2_match;
  logic kill;
  logic hazard;
  logic stall;
  logic issue_write;

  // ---------------------------------------------------------------------------
  // Scoreboard lookup. Only valid entries hold a nonzero rd, but x0 is excluded
  // explicitly so a source of x0 can never match.
  // ---------------------------------------------------------------------------
  always_comb begin
    rs1_match = 1'b0;
    rs2_match = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (sb_q[i].valid && (sb_q[i].rd == D_RS1)) rs1_match = 1'b1;
      if (sb_q[i].valid && (sb_q[i].rd == D_RS2)) rs2_match = 1'b1;
    end
    rs1_match = rs1_match && (D_RS1 != 5'd0);
    rs2_match = rs2_match && (D_RS2 != 5'd0);
  end

  // ---------------------------------------------------------------------------
  // Hazard / kill decisions. A redirect wins over a hazard: the decode
  // instruction is bubbled rather than held. Everything is silenced in reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    kill   = REDIRECT || (shadow_cnt_q != 2'd0);
    hazard = (D_USE_RS1 && rs1_match) || (D_USE_RS2 && rs2_match);
    stall  = !RESET && D_VALID && !kill && hazard;

    STALL     = stall;
    BUBBLE_DE = !RESET && (stall || kill);
    FLUSH_FD  = !RESET && kill;
    SB_BUSY   = RESET ? 3'b000 : {sb_q[2].valid, sb_q[1].valid, sb_q[0].valid};
    STALL_CNT = stall_cnt_q;
    FLUSH_CNT = flush_cnt_q;
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // Only an instruction that actually advances into E claims an entry.
    issue_write = D_VALID && D_REGWRT && (D_RD != 5'd0) && !stall && !kill;

    sb_d[2] = sb_q[1];
    sb_d[1] = sb_q[0];
    if (issue_write) begin
      sb_d[0] = '{valid: 1'b1, rd: D_RD};
    end else begin
      sb_d[0] = '{valid: 1'b0, rd: 5'd0};
    end

    // A redirect reloads the window rather than extending it.
    if (REDIRECT) begin
      shadow_cnt_d = 2'(SHADOW);
    end else if (shadow_cnt_q != 2'd0) begin
      shadow_cnt_d = shadow_cnt_q - 2'd1;
    end else begin
      shadow_cnt_d = 2'd0;
    end

    stall_cnt_d = stall    ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = REDIRECT ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sb_q         <= '0;
      shadow_cnt_q <= 2'd0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      sb_q         <= sb_d;
      shadow_cnt_q <= shadow_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

endmodule
